// File: rtl/prime_scan_ctrl.sv
// prime_scan_ctrl: sequences an external 4-bit combinational prime detector
// across a latched inclusive range [Lo, Hi], one value per clock.
// While it scans, it counts the primes and records the largest one.
// It reports the results with a one-cycle Done pulse.
// Optional feature macro: PRIME_SCAN_MAP_EN adds a 16-bit Map output.
// Map has one bit per detected prime.
module prime_scan_ctrl (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [3:0]  Lo,
  input  logic [3:0]  Hi,
  output logic [3:0]  Num,
  input  logic        Prime,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [4:0]  Count,
  output logic        Found,
  output logic [3:0]  Last
`ifdef PRIME_SCAN_MAP_EN
  ,
  output logic [15:0] Map
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] hi_q;

  // Count saturates rather than wraps; a 0..15 range tops out at 6 primes.
  function automatic logic [4:0] count_inc(input logic [4:0] c);
    if (c == 5'd31) return c;
    return c + 5'd1;
  endfunction

  // Scan sequencer: the state, the range, the results and the Busy/Done flags are all registered here.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      hi_q  <= '0;
      Num   <= '0;
      Count <= '0;
      Last  <= '0;
      Found <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Err   <= 1'b0;
`ifdef PRIME_SCAN_MAP_EN
      Map   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            Count <= '0;
            Last  <= '0;
            Found <= 1'b0;
`ifdef PRIME_SCAN_MAP_EN
            Map   <= '0;
`endif
            if (Lo <= Hi) begin
              state <= SCAN;
              Busy  <= 1'b1;
              hi_q  <= Hi;
              Num   <= Lo;
              Err   <= 1'b0;
            end else begin
              // An inverted range skips the scan entirely; Num keeps its old value.
              state <= DONE;
              Done  <= 1'b1;
              Err   <= 1'b1;
            end
          end
        end
        SCAN: begin
          // Values rise in ascending order, so the most recent prime is also the largest.
          if (Prime) begin
            Count <= count_inc(Count);
            Last  <= Num;
            Found <= 1'b1;
`ifdef PRIME_SCAN_MAP_EN
            Map[Num] <= 1'b1;
`endif
          end
          // Testing equality before incrementing means Hi=15 never wraps Num back to 0.
          if (Num == hi_q) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            Num <= Num + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          Done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
